// File: rtl/gameplay_sequencer_pkg.sv
// gameplay_sequencer_pkg: state encoding shared by the sequencer and the debug decode of state
package gameplay_sequencer_pkg;
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_SWING  = 4'd2;
  localparam logic [3:0] S_DROP   = 4'd3;
  localparam logic [3:0] S_STEP   = 4'd4;
  localparam logic [3:0] S_SETTLE = 4'd5;
  localparam logic [3:0] S_JUDGE  = 4'd6;
  localparam logic [3:0] S_HIT    = 4'd7;
  localparam logic [3:0] S_MISS   = 4'd8;
  localparam logic [3:0] S_CHECK  = 4'd9;
  localparam logic [3:0] S_OVER   = 4'd10;
  localparam logic [3:0] S_WIN    = 4'd11;
endpackage

// File: rtl/gameplay_sequencer_edge_detect.sv
// edge_detect: one-cycle pulse on each rising edge of an already synchronised level
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk)
    q <= resetn ? d : 1'b0;
  assign rise = d & ~q;
endmodule

// File: rtl/gameplay_sequencer.sv
// gameplay_sequencer: Moore FSM that loads, swings, drops and scores each block of a stacking game
module gameplay_sequencer
  import gameplay_sequencer_pkg::*;
#(
  parameter logic [7:0] START_X = 8'd0,
  parameter logic [6:0] TOP_Y   = 7'd0,
  parameter logic [6:0] BASE_Y  = 7'd112,
  parameter logic [6:0] BLOCK_H = 7'd4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       sync,
  input  logic       o,
  input  logic       c,
  input  logic [6:0] curr_y_position,
  output logic       enable,
  output logic       save_x,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_d,
  output logic       inc_score,
  output logic       dec_chances,
  output logic       new_direction,
  output logic [7:0] new_x_position,
  output logic [6:0] new_y_position,
  output logic       game_over,
  output logic       win,
  output logic [3:0] state
);
  localparam logic [6:0] WIN_Y = TOP_Y + BLOCK_H;
  logic       go_rise, first, dir, w;
  logic [6:0] stack_y;
  logic [3:0] nxt;
  edge_detect u_go (.clk(clk), .resetn(resetn), .d(go), .rise(go_rise));
  always_ff @(posedge clk)
    state <= resetn ? nxt : S_IDLE;
  // Each DROP step detours through STEP so the ld_y strobe stays a pure state decode.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:         nxt = go_rise ? S_LOAD : S_IDLE;
      S_LOAD:         nxt = S_SWING;
      S_SWING:        nxt = go_rise ? S_DROP : S_SWING;
      S_DROP:         nxt = curr_y_position >= stack_y ? S_SETTLE : sync ? S_STEP : S_DROP;
      S_STEP:         nxt = S_DROP;
      S_SETTLE:       nxt = w ? S_JUDGE : S_SETTLE;
      S_JUDGE:        nxt = (first | o) ? S_HIT : S_MISS;
      S_HIT, S_MISS:  nxt = S_CHECK;
      S_CHECK:        nxt = !w ? S_CHECK : !c ? S_OVER : stack_y < WIN_Y ? S_WIN : S_LOAD;
      S_OVER, S_WIN:  nxt = go_rise ? S_IDLE : state;
      default:        nxt = S_IDLE;
    endcase
  end
  always_comb begin
    enable      = state == S_SWING;
    ld_x        = state == S_LOAD;
    ld_d        = state == S_LOAD;
    ld_y        = state == S_LOAD || state == S_STEP;
    save_x      = state == S_HIT;
    inc_score   = state == S_HIT;
    dec_chances = state == S_MISS;
    game_over   = state == S_OVER || state == S_WIN;
    win         = state == S_WIN;
  end
  // w marks the second cycle of the two-cycle SETTLE and CHECK waits.
  always_ff @(posedge clk) begin
    new_x_position <= START_X;
    if (!resetn) begin
      stack_y        <= BASE_Y;
      first          <= 1'b1;
      dir            <= 1'b1;
      w              <= 1'b0;
      new_y_position <= TOP_Y;
      new_direction  <= 1'b1;
    end else begin
      w             <= (state == S_SETTLE || state == S_CHECK) && !w;
      new_direction <= dir;
      if (state == S_IDLE) begin
        stack_y <= BASE_Y;
        first   <= 1'b1;
        dir     <= 1'b1;
      end
      if (state == S_HIT) begin
        stack_y <= stack_y - BLOCK_H;
        first   <= 1'b0;
      end
      if (state == S_HIT || state == S_MISS) dir <= ~dir;
      if (state == S_DROP && nxt == S_STEP) new_y_position <= curr_y_position + 7'd1;
      else if (nxt == S_LOAD) new_y_position <= TOP_Y;
    end
  end
endmodule

// File: tb/tb_gameplay_sequencer.sv
// tb_gameplay_sequencer: scoreboard bench with a small datapath model driven by the sequencer strobes
module tb_gameplay_sequencer;
  import gameplay_sequencer_pkg::*;
  logic       clk = 0, resetn = 0, go = 0, sync = 0, o = 0, c;
  logic [6:0] curr_y;
  logic       enable, save_x, ld_x, ld_y, ld_d, inc_score, dec_chances, new_direction, game_over, win;
  logic [7:0] new_x_position;
  logic [6:0] new_y_position;
  logic [3:0] state;
  int         chances, score, passed = 0, total = 0, steps = 0;
  int         stack_m, chances_m;
  bit         first_m, dir_m;
  typedef struct { bit hit; int steps; } exp_t;
  exp_t q[$];

  gameplay_sequencer dut (
    .clk(clk), .resetn(resetn), .go(go), .sync(sync), .o(o), .c(c),
    .curr_y_position(curr_y), .enable(enable), .save_x(save_x), .ld_x(ld_x),
    .ld_y(ld_y), .ld_d(ld_d), .inc_score(inc_score), .dec_chances(dec_chances),
    .new_direction(new_direction), .new_x_position(new_x_position),
    .new_y_position(new_y_position), .game_over(game_over), .win(win), .state(state)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1 sync = ~sync;
  end

  always @(posedge clk) begin
    if (!resetn) begin
      curr_y <= 7'd0; chances <= 10; c <= 1'b1; score <= 0;
    end else begin
      if (ld_y) curr_y <= new_y_position;
      if (dec_chances) chances <= chances - 1;
      c <= chances != 0;
      if (inc_score) score <= score + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      steps = 0;
    end else begin
      if (ld_y && !ld_x) steps++;
      if (inc_score || dec_chances) begin
        if (q.size() == 0) check("unexpected_strobe", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("inc_score", inc_score, e.hit);
          check("dec_chances", dec_chances, !e.hit);
          check("save_x", save_x, e.hit);
          check("drop_steps", steps, e.steps);
        end
        steps = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input logic [3:0] s, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = state == s;
    end
    if (!ok) check("timeout", state, s);
  endtask

  task automatic start_game();
    stack_m = 112; first_m = 1; dir_m = 1;
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    check("load_state", state, S_LOAD);
    check("load_ld_x", ld_x, 1);
    check("load_ld_y", ld_y, 1);
    check("load_ld_d", ld_d, 1);
    check("load_x", new_x_position, 0);
    check("load_y", new_y_position, 0);
    check("load_dir", new_direction, 1);
    tick(1);
    check("swing_enable", enable, 1);
    tick(3);
    check("swing_hold", enable, 1);
  endtask

  task automatic drop(input bit poke);
    exp_t e;
    logic [3:0] want;
    e.hit = first_m || o;
    e.steps = stack_m;
    q.push_back(e);
    if (e.hit) begin stack_m -= 4; first_m = 0; end
    else chances_m--;
    dir_m = !dir_m;
    go = 1;
    tick(1);
    go = 0;
    check("enable_off", enable, 0);
    check("drop_state", state, S_DROP);
    if (poke) begin
      tick(5);
      go = 1;
      tick(1);
      go = 0;
      check("drop_ignores_go", int'(state == S_DROP || state == S_STEP), 1);
    end
    wait_for(S_CHECK, 1000);
    if (poke) go = 1;
    tick(1);
    go = 0;
    check("check_hold", state, S_CHECK);
    want = chances_m == 0 ? S_OVER : stack_m < 4 ? S_WIN : S_LOAD;
    tick(1);
    check("after_check", state, want);
    if (want == S_LOAD) begin
      check("next_dir", new_direction, dir_m);
      check("reload_y", new_y_position, 0);
      tick(1);
      repeat (4) begin
        check("swing_again", enable, 1);
        tick(1);
      end
    end
  endtask

  initial begin
    chances_m = 10;
    tick(2);
    check("rst_state", state, S_IDLE);
    check("rst_strobes", {enable, save_x, ld_x, ld_y, ld_d, inc_score, dec_chances}, 0);
    check("rst_over", {game_over, win}, 0);
    check("rst_x", new_x_position, 0);
    check("rst_y", new_y_position, 0);
    check("rst_dir", new_direction, 1);
    resetn = 1;
    tick(1);
    start_game();
    o = 0;
    drop(1);
    check("score_first", score, 1);
    drop(0);
    check("chances_9", chances, 9);
    for (int i = 0; i < 9; i++) drop(0);
    check("over_flag", game_over, 1);
    check("over_win", win, 0);
    check("chances_0", chances, 0);
    go = 1;
    tick(1);
    go = 0;
    check("over_to_idle", state, S_IDLE);
    resetn = 0;
    chances_m = 10;
    tick(2);
    resetn = 1;
    tick(1);
    start_game();
    o = 1;
    for (int i = 0; i < 28; i++) drop(0);
    check("win_flag", win, 1);
    check("win_over", game_over, 1);
    check("score_win", score, 28);
    repeat (5) begin
      tick(1);
      check("win_hold", state, S_WIN);
      check("no_third_load", ld_x, 0);
    end
    go = 1;
    tick(1);
    go = 0;
    check("win_to_idle", state, S_IDLE);
    start_game();
    go = 1;
    tick(1);
    go = 0;
    tick(30);
    check("mid_drop", int'(state == S_DROP || state == S_STEP), 1);
    resetn = 0;
    tick(1);
    check("reset_idle", state, S_IDLE);
    check("reset_strobes", {enable, save_x, ld_x, ld_y, ld_d, inc_score, dec_chances}, 0);
    resetn = 1;
    tick(2);
    check("stays_idle", state, S_IDLE);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/gameplay_sequencer.md
# gameplay_sequencer

Moore control FSM that sequences `gameplay_datapath` through one full game of stacking blocks. It loads each new block at the top of the screen and lets the block swing horizontally until the player drops it. It then steps the block down to the current stack height, samples the overlap flag and issues score or chance updates. The block sits between the board I/O (start/drop key, frame tick) and the datapath control inputs.

## Interface
- `START_X`, 8'd0: x position loaded for every new block
- `TOP_Y`, 7'd0: y position loaded for every new block
- `BASE_Y`, 7'd112: landing y of the first block
- `BLOCK_H`, 7'd4: stack rise per successful hit
- `clk` in 1: 50 MHz system clock
- `resetn` in 1: synchronous, active-low reset
- `go` in 1: player key, level, already synchronised; start in IDLE, drop in SWING
- `sync` in 1: one-cycle frame tick; same signal that feeds the datapath
- `o` in 1: overlap flag from the datapath (registered, 1-cycle latency after x change)
- `c` in 1: chances-left flag from the datapath (registered from `chances`)
- `curr_y_position` in 7: datapath y readback
- `enable`, `save_x`, `ld_x`, `ld_y`, `ld_d`, `inc_score`, `dec_chances` out 1: datapath controls
- `new_direction` out 1: direction loaded with `ld_d`; 1 = rightward
- `new_x_position` out 8: value for `ld_x`
- `new_y_position` out 7: value for `ld_y`
- `game_over` out 1: high in OVER and WIN
- `win` out 1: high in WIN only
- `state` out 4: current state encoding (debug)

## Operation
- `go` is edge-detected internally as `go_rise = go & ~go_q`. Only rising edges act.
- States and transitions:
  - IDLE: on `go_rise` go to LOAD. Also clear `stack_y` to BASE_Y, set `first` to 1 and set `dir` to 1.
  - LOAD: for one cycle, assert `ld_x`, `ld_y` and `ld_d`, with `new_x_position` = START_X, `new_y_position` = TOP_Y and `new_direction` = `dir`. Then go to SWING.
  - SWING: assert `enable`. On `go_rise`, go to DROP.
  - DROP: on each `sync`, while `curr_y_position` < `stack_y`, assert `ld_y` for one cycle with `new_y_position` = `curr_y_position` + 1. When `curr_y_position` == `stack_y`, go to SETTLE.
  - SETTLE: wait 2 cycles for the `o` pipeline, then go to JUDGE.
  - JUDGE:
    - If `first` or `o` is high, go to HIT.
    - Otherwise go to MISS.
  - HIT: for one cycle, assert `inc_score` and `save_x`. Set `stack_y` to `stack_y` − BLOCK_H, clear `first` and toggle `dir`. Then go to CHECK.
  - MISS: for one cycle, assert `dec_chances` and toggle `dir`. Then go to CHECK.
  - CHECK: wait 2 cycles so that `c` reflects the updated `chances`. Then:
    - If `c` is 0, go to OVER.
    - Else if `stack_y` < TOP_Y + BLOCK_H, go to WIN.
    - Otherwise go to LOAD.
  - OVER and WIN: hold. On `go_rise`, go to IDLE.
- `stack_y` arithmetic is 7-bit unsigned. The WIN test must be evaluated before the subtraction could wrap, so `stack_y` never underflows.
- `go_rise` outside IDLE, SWING, OVER and WIN is ignored and never queued.

## Timing
- Reset values:
  - state = IDLE; all control outputs are 0.
  - `new_x_position` = START_X, `new_y_position` = TOP_Y, `new_direction` = 1.
  - `game_over` = 0, `win` = 0.
  - `stack_y` = BASE_Y, `first` = 1, `dir` = 1, `go_q` = 0.
- The datapath must be reset by the same `resetn`.
- Control outputs are combinational decodes of the state register (Moore). `new_*` outputs are registered and must be stable in the cycle their load strobe is high.
- Every strobe except `enable` is exactly one cycle wide per event.
- Latency:
  - `go_rise` in SWING: `enable` drops on the next cycle.
  - Landing to HIT/MISS strobe: 3 cycles.
- A `sync` arriving in the same cycle as the SWING→DROP transition is not used for a step.
- `resetn` low mid-game forces IDLE on the next edge, regardless of state.

## Structure
- A shared package holds the state encoding localparams, shared with the display/debug logic that decodes `state`.
- The rising-edge detector is a natural sub-module: `edge_detect`. Use it for `go`.
- Everything else stays in one FSM file.

## Test plan
- Reset, then `go` pulse: one cycle of LOAD, with `ld_x`/`ld_y`/`ld_d` = 1, x = 0, y = 0, dir = 1, then `enable` held high.
- First drop with BASE_Y = 112: exactly 112 `ld_y` steps, then `inc_score` with `o` ignored. Score becomes 1 and `stack_y` becomes 108.
- Second drop with `o` forced to 0: `dec_chances` pulses once and chances go 10→9. There is no `save_x`, `stack_y` stays 108, and `dir` for the next LOAD is 1.
- Ten consecutive misses after the first hit: `game_over` = 1, `win` = 0. A further `go` returns the FSM to IDLE.
- With BASE_Y = 8, BLOCK_H = 4 and `o` forced to 1: after 2 hits, `stack_y` = 0, which is < 4, so `win` = 1 and no third LOAD occurs.
- `resetn` asserted during DROP: next cycle the state is IDLE and all strobes are 0. `go` presses during DROP/SETTLE/CHECK produce no transition.
